// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg
//   Shared definitions for the frame loader: controller state encoding,
//   default frame geometry and the "no digit" result code.
package frame_loader_pkg;

   typedef enum logic [2:0] {
      LOAD,
      START,
      WAIT_LOW,
      RUN,
      RESULT
   } state_t;

   localparam int         PICTURE_SIZE_DEF = 28;
   localparam int         N_PIX            = PICTURE_SIZE_DEF ** 2;
   localparam logic [3:0] DIGIT_NONE       = 4'hF;

   // Number of pixels in a square frame with the given edge length.
   function automatic int frame_len(input int edge_len);
      return edge_len * edge_len;
   endfunction

endpackage

// File: rtl/frame_loader_if.sv
// frame_loader_if
//   Bundles every non-clock signal of the frame loader:
//     pixel stream   : s_valid, s_ready, s_data, s_last
//     database write : we_database, dp_database, address_p_database
//     core control   : GO, STOP, RESULT
//     result port    : res_valid, res_ready, res_digit
//     error pulses   : err_frame, err_timeout
//   Modports:
//     slave  - the loader itself (consumes pixels, drives database/core/result)
//     master - the surrounding environment (pixel source, core, result sink)
interface frame_loader_if #(
   parameter int SIZE_1 = 12,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 13
);
   logic                     s_valid;
   logic                     s_ready;
   logic [PIX_W-1:0]         s_data;
   logic                     s_last;
   logic                     we_database;
   logic signed [SIZE_1-1:0] dp_database;
   logic [ADDR_W-1:0]        address_p_database;
   logic                     GO;
   logic                     STOP;
   logic [3:0]               RESULT;
   logic                     res_valid;
   logic                     res_ready;
   logic [3:0]               res_digit;
   logic                     err_frame;
   logic                     err_timeout;

   modport slave (
      input  s_valid, s_data, s_last, STOP, RESULT, res_ready,
      output s_ready, we_database, dp_database, address_p_database, GO,
             res_valid, res_digit, err_frame, err_timeout
   );

   modport master (
      output s_valid, s_data, s_last, STOP, RESULT, res_ready,
      input  s_ready, we_database, dp_database, address_p_database, GO,
             res_valid, res_digit, err_frame, err_timeout
   );
endinterface

// File: rtl/frame_loader_run_watchdog.sv
// run_watchdog
//   Cycle counter bounding how long the core may take to finish.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clr      : restart the count at zero (synchronous)
//     en       : count this cycle
//     expire   : high in the enabled cycle where the count is TIMEOUT-1,
//                so a registered reaction lands TIMEOUT cycles after clr
module run_watchdog #(
   parameter int TIMEOUT = 1048576
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int              WD_W    = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd <= '0;
      end else if (clr) begin
         wd <= '0;
      end else if (en) begin
         wd <= wd + 1'b1;
      end
   end

   assign expire = en && (wd == WD_LAST);
endmodule

// File: rtl/frame_loader.sv
// frame_loader
//   Streams one PICTURE_SIZE x PICTURE_SIZE frame into the digit core's image
//   database, starts the core, waits for it to finish (bounded by a watchdog)
//   and offers the classified digit on a valid/ready result port.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : frame_loader_if.slave (pixel stream, database write port,
//                GO/STOP/RESULT core handshake, result port, error pulses)
//   Every output is registered. PIX_W + PIX_SHIFT must not exceed SIZE_1-1 so
//   converted pixels stay non-negative in the signed core word.
module frame_loader
   import frame_loader_pkg::*;
#(
   parameter int SIZE_1       = 12,
   parameter int PIX_W        = 8,
   parameter int PIX_SHIFT    = 3,
   parameter int PICTURE_SIZE = 28,
   parameter int ADDR_W       = 13,
   parameter int TIMEOUT      = 1048576
) (
   input  logic           clk,
   input  logic           rst,
   frame_loader_if.slave  bus
);
   localparam int                FRAME_N  = frame_len(PICTURE_SIZE);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_N - 1);

   // Unsigned pixel scaled into the signed core word; the top bits stay zero.
   function automatic logic signed [SIZE_1-1:0] pix_to_word(input logic [PIX_W-1:0] pix);
      logic [SIZE_1-1:0] w;
      w = SIZE_1'(pix) << PIX_SHIFT;
      return $signed(w);
   endfunction

   state_t                   state, state_nxt;
   logic [ADDR_W-1:0]        cnt, cnt_nxt;
   logic                     s_ready_nxt, we_nxt, go_nxt, res_valid_nxt;
   logic                     err_frame_nxt, err_timeout_nxt;
   logic [ADDR_W-1:0]        addr_nxt;
   logic signed [SIZE_1-1:0] dp_nxt;
   logic [3:0]               res_digit_nxt;
   logic                     beat, wd_clr, wd_en, wd_expire;

   assign beat = bus.s_valid & bus.s_ready;

   run_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk    (clk),
      .rst    (rst),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      we_nxt          = 1'b0;
      addr_nxt        = bus.address_p_database;
      dp_nxt          = bus.dp_database;
      go_nxt          = 1'b0;
      res_valid_nxt   = bus.res_valid;
      res_digit_nxt   = bus.res_digit;
      err_frame_nxt   = 1'b0;
      err_timeout_nxt = 1'b0;
      wd_clr          = 1'b0;
      wd_en           = 1'b0;

      case (state)
         LOAD: begin
            if (beat) begin
               we_nxt   = 1'b1;
               addr_nxt = cnt;
               dp_nxt   = pix_to_word(bus.s_data);
               // The last slot always closes the frame; s_last only decides
               // whether that closing is reported as a length error.
               if (cnt == LAST_IDX) begin
                  cnt_nxt       = '0;
                  err_frame_nxt = ~bus.s_last;
                  state_nxt     = START;
               end else if (bus.s_last) begin
                  cnt_nxt       = '0;
                  err_frame_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         START: begin
            go_nxt    = 1'b1;
            wd_clr    = 1'b1;
            state_nxt = WAIT_LOW;
         end
         WAIT_LOW: begin
            wd_en = 1'b1;
            if (wd_expire) begin
               err_timeout_nxt = 1'b1;
               res_digit_nxt   = DIGIT_NONE;
               res_valid_nxt   = 1'b1;
               state_nxt       = RESULT;
            end else if (!bus.STOP) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            wd_en = 1'b1;
            // A finished core wins over a watchdog expiring in the same cycle.
            if (bus.STOP) begin
               res_digit_nxt = bus.RESULT;
               res_valid_nxt = 1'b1;
               state_nxt     = RESULT;
            end else if (wd_expire) begin
               err_timeout_nxt = 1'b1;
               res_digit_nxt   = DIGIT_NONE;
               res_valid_nxt   = 1'b1;
               state_nxt       = RESULT;
            end
         end
         RESULT: begin
            if (bus.res_ready) begin
               res_valid_nxt = 1'b0;
               cnt_nxt       = '0;
               state_nxt     = LOAD;
            end
         end
         default: begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
         end
      endcase

      s_ready_nxt = (state_nxt == LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= LOAD;
         cnt                    <= '0;
         bus.s_ready            <= 1'b1;
         bus.we_database        <= 1'b0;
         bus.address_p_database <= '0;
         bus.dp_database        <= '0;
         bus.GO                 <= 1'b0;
         bus.res_valid          <= 1'b0;
         bus.res_digit          <= DIGIT_NONE;
         bus.err_frame          <= 1'b0;
         bus.err_timeout        <= 1'b0;
      end else begin
         state                  <= state_nxt;
         cnt                    <= cnt_nxt;
         bus.s_ready            <= s_ready_nxt;
         bus.we_database        <= we_nxt;
         bus.address_p_database <= addr_nxt;
         bus.dp_database        <= dp_nxt;
         bus.GO                 <= go_nxt;
         bus.res_valid          <= res_valid_nxt;
         bus.res_digit          <= res_digit_nxt;
         bus.err_frame          <= err_frame_nxt;
         bus.err_timeout        <= err_timeout_nxt;
      end
   end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader
//   Directed bench for frame_loader with a queue-based write model, a core
//   model driving STOP/RESULT, and one compare process sampling on negedge.
module tb_frame_loader;
   import frame_loader_pkg::*;

   localparam int SIZE_1    = 12;
   localparam int PIX_W     = 8;
   localparam int PIX_SHIFT = 3;
   localparam int ADDR_W    = 13;
   localparam int TMO       = 64;
   localparam int NPIX      = N_PIX;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   frame_loader_if #(.SIZE_1(SIZE_1), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

   frame_loader #(
      .SIZE_1(SIZE_1), .PIX_W(PIX_W), .PIX_SHIFT(PIX_SHIFT),
      .PICTURE_SIZE(PICTURE_SIZE_DEF), .ADDR_W(ADDR_W), .TIMEOUT(TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t  exp_q[$];
   int   checks = 0, errors = 0;
   int   cyc = 0;
   int   m_cnt = 0;
   int   exp_ef = 0;
   int   go_cnt = 0, ef_cnt = 0, et_cnt = 0, wr_cnt = 0;
   int   go_cyc = -1000, fin_wr_cyc = -1000;
   int   dp255 = -1, dp_last = -1;
   logic go_prev = 1'b0, ef_prev = 1'b0, et_prev = 1'b0;
   logic exp_ready = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Compare process
   always @(negedge clk) begin
      wr_t e;
      if (!rst) begin
         chk("s_ready", bus.s_ready, exp_ready);
         if (bus.we_database === 1'b1) begin
            wr_cnt++;
            chk("wr_pending", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", bus.address_p_database, e.addr);
               chk("wr_data", bus.dp_database, e.data);
            end
            if (int'(bus.address_p_database) == 255) dp255 = int'(bus.dp_database);
            if (int'(bus.address_p_database) == NPIX - 1) begin
               fin_wr_cyc = cyc;
               dp_last    = int'(bus.dp_database);
            end
         end
         if (bus.GO === 1'b1) begin
            go_cnt++;
            chk("go_latency", cyc, fin_wr_cyc + 1);
            chk("go_width", go_prev, 0);
            go_cyc = cyc;
         end
         if (bus.err_frame === 1'b1) begin
            ef_cnt++;
            chk("err_frame_align", bus.we_database, 1);
            chk("err_frame_width", ef_prev, 0);
         end
         if (bus.err_timeout === 1'b1) begin
            et_cnt++;
            chk("timeout_latency", cyc, go_cyc + TMO);
            chk("timeout_width", et_prev, 0);
            chk("timeout_valid", bus.res_valid, 1);
            chk("timeout_digit", bus.res_digit, 15);
         end
         go_prev = bus.GO;
         ef_prev = bus.err_frame;
         et_prev = bus.err_timeout;
      end else begin
         go_prev = 1'b0;
         ef_prev = 1'b0;
         et_prev = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives nbeats pixels (value = beat index mod 256); s_last on beat last_at.
   task automatic send_beats(input int nbeats, input int last_at);
      bit final_beat, is_last;
      for (int i = 0; i < nbeats; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = PIX_W'(i % 256);
         bus.s_last  = (i == last_at);
         exp_q.push_back('{addr: m_cnt, data: (i % 256) << PIX_SHIFT});
         final_beat = (m_cnt == NPIX - 1);
         is_last    = (i == last_at);
         if (final_beat) begin
            if (!is_last) exp_ef++;
            m_cnt = 0;
         end else if (is_last) begin
            exp_ef++;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
         step();
         if (final_beat) exp_ready = 1'b0;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic wait_go();
      int n = 0;
      while (bus.GO !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk("go_seen", bus.GO, 1);
   endtask

   // mode 0: normal completion; 1: core hangs in RUN; 2: core never acknowledges
   task automatic run_core(input int digit, input int mode);
      int n = 0;
      wait_go();
      if (mode == 0) begin
         step();
         bus.STOP   = 1'b0;
         bus.RESULT = 4'h3;
         step();
         bus.STOP   = 1'b1;
         bus.RESULT = 4'(digit);
         chk("res_valid_before", bus.res_valid, 0);
         step();
         chk("res_valid", bus.res_valid, 1);
         chk("res_digit", bus.res_digit, digit);
      end else begin
         step();
         if (mode == 1) bus.STOP = 1'b0;
         while (bus.err_timeout !== 1'b1 && n < TMO + 10) begin
            step();
            n++;
         end
         chk("timeout_seen", bus.err_timeout, 1);
         chk("timeout_res_valid", bus.res_valid, 1);
         bus.STOP = 1'b1;
      end
   endtask

   task automatic accept_result(input int digit, input int hold);
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", bus.res_valid, 1);
         chk("hold_digit", bus.res_digit, digit);
         chk("hold_s_ready", bus.s_ready, 0);
         step();
      end
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      exp_ready     = 1'b1;
      chk("s_ready_after_hs", bus.s_ready, 1);
      chk("res_valid_clear", bus.res_valid, 0);
   endtask

   task automatic check_reset_vals();
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_we", bus.we_database, 0);
      chk("rst_addr", bus.address_p_database, 0);
      chk("rst_dp", bus.dp_database, 0);
      chk("rst_go", bus.GO, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_digit", bus.res_digit, 15);
      chk("rst_err_frame", bus.err_frame, 0);
      chk("rst_err_timeout", bus.err_timeout, 0);
   endtask

   task automatic mid_reset();
      rst = 1'b1;
      exp_q.delete();
      m_cnt     = 0;
      exp_ready = 1'b1;
      #1;
      check_reset_vals();
      bus.STOP = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: bench stalled at cycle %0d", cyc);
      $fatal(1, "bench stalled");
   end

   initial begin
      int ef0, go0, et0;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.s_last    = 1'b0;
      bus.STOP      = 1'b1;
      bus.RESULT    = 4'h0;
      bus.res_ready = 1'b0;
      #1 rst = 1'b1;
      #1 check_reset_vals();
      step();
      step();
      rst = 1'b0;
      step();

      // Nominal frame
      send_beats(NPIX, NPIX - 1);
      run_core(7, 0);
      chk("nominal_writes", wr_cnt, 784);
      chk("dp_pix255", dp255, 2040);
      chk("dp_pix783", dp_last, 120);
      chk("nominal_go", go_cnt, 1);
      chk("nominal_err_frame", ef_cnt, 0);
      accept_result(7, 2);

      // Early s_last, then a full frame
      go0 = go_cnt;
      send_beats(100, 99);
      repeat (4) step();
      chk("early_err_frame", ef_cnt, 1);
      chk("early_no_go", go_cnt, go0);
      chk("early_drained", exp_q.size(), 0);
      send_beats(NPIX, NPIX - 1);
      run_core(3, 0);
      accept_result(3, 1);

      // Missing s_last on the final beat
      ef0 = ef_cnt;
      go0 = go_cnt;
      send_beats(NPIX, -1);
      run_core(5, 0);
      chk("missing_err_frame", ef_cnt - ef0, 1);
      chk("missing_go", go_cnt - go0, 1);
      accept_result(5, 1);

      // Watchdog in RUN, then result backpressure
      et0 = et_cnt;
      send_beats(NPIX, NPIX - 1);
      run_core(0, 1);
      accept_result(15, 20);
      chk("wd_run_pulses", et_cnt - et0, 1);

      // Watchdog while waiting for the core to acknowledge
      send_beats(NPIX, NPIX - 1);
      run_core(0, 2);
      accept_result(15, 2);
      chk("wd_wait_pulses", et_cnt - et0, 2);

      // Reset during frame load, then a full frame from address 0
      send_beats(400, -1);
      mid_reset();
      send_beats(NPIX, NPIX - 1);
      run_core(2, 0);
      accept_result(2, 1);

      // Reset while the core runs
      send_beats(NPIX, NPIX - 1);
      wait_go();
      step();
      bus.STOP = 1'b0;
      step();
      step();
      mid_reset();
      go0 = go_cnt;
      repeat (5) step();
      chk("no_go_after_reset", go_cnt, go0);
      send_beats(NPIX, NPIX - 1);
      run_core(9, 0);
      accept_result(9, 1);

      repeat (3) step();
      chk("queue_empty", exp_q.size(), 0);
      chk("err_frame_total", ef_cnt, exp_ef);
      chk("err_timeout_total", et_cnt, 2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
